// File: rtl/spi_frame_loader.sv
// spi_frame_loader: SPI packet parser feeding the LED cube frame buffer.
// Turns framed host packets into pixel writes and buffer-swap requests.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   spi_sclk/cs_n/mosi    mode-0 SPI from host (async to clk)
//   wr_en/wr_addr/wr_data one-cycle pixel write {R,G,B}
//   swap                  one-cycle front/back buffer swap request
//   pkt_error             one-cycle pulse on a malformed packet
//   busy                  synchronised chip select is asserted
module spi_frame_loader #(
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] CMD_WRITE = 8'h01,
    parameter logic [7:0] CMD_SWAP  = 8'h02
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              swap,
    output logic              pkt_error,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_SWAP_WAIT,
        S_DISCARD
    } state_t;

    // synchronisers
    logic sclk_m, sclk_s, sclk_p;
    logic cs_m, cs_s, cs_p;
    logic mosi_m, mosi_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_m <= 1'b0;
            sclk_s <= 1'b0;
            sclk_p <= 1'b0;
            // idle-high so reset release cannot fake a cs falling edge
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
            cs_p   <= 1'b1;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sclk_m <= spi_sclk;
            sclk_s <= sclk_m;
            sclk_p <= sclk_s;
            cs_m   <= spi_cs_n;
            cs_s   <= cs_m;
            cs_p   <= cs_s;
            mosi_m <= spi_mosi;
            mosi_s <= mosi_m;
        end
    end

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    assign sclk_rise = sclk_s & ~sclk_p;
    assign cs_fall   = ~cs_s & cs_p;
    assign cs_rise   = cs_s & ~cs_p;

    // bit assembly
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_done;
    logic [7:0] byte_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
        end else if (cs_s) begin
            bit_cnt <= 3'd0;
            shreg   <= 7'd0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[5:0], mosi_s};
        end
    end

    // The byte is consumed in the cycle its last bit is detected, so
    // every FSM result (including wr_en) is visible one clock later.
    assign byte_done = sclk_rise & ~cs_s & (bit_cnt == 3'd7);
    assign byte_in   = {shreg, mosi_s};

    // packet FSM state
    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        r_q, r_d;
    logic [7:0]        g_q, g_d;
    logic              rx_any_q, rx_any_d;
    logic              extra_q, extra_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [23:0]       wr_data_d;
    logic              swap_d;
    logic              err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            addr_q    <= '0;
            hi_q      <= 8'd0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            rx_any_q  <= 1'b0;
            extra_q   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 24'd0;
            swap      <= 1'b0;
            pkt_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            r_q       <= r_d;
            g_q       <= g_d;
            rx_any_q  <= rx_any_d;
            extra_q   <= extra_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            swap      <= swap_d;
            pkt_error <= err_d;
            busy      <= ~cs_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        r_d       = r_q;
        g_d       = g_q;
        rx_any_d  = rx_any_q;
        extra_d   = extra_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        swap_d    = 1'b0;
        err_d     = 1'b0;

        if (cs_rise) begin
            // end of packet: judge what was received, then go idle
            state_d  = S_IDLE;
            phase_d  = 2'd0;
            rx_any_d = 1'b0;
            extra_d  = 1'b0;
            unique case (state_q)
                S_SWAP_WAIT: begin
                    if (extra_q) err_d  = 1'b1;
                    else         swap_d = 1'b1;
                end
                S_DATA: begin
                    if (phase_q != 2'd0 || bit_cnt != 3'd0)
                        err_d = 1'b1;
                end
                S_CMD, S_ADDR_HI, S_ADDR_LO: begin
                    if (rx_any_q) err_d = 1'b1;
                end
                default: ;
            endcase
        end else begin
            if (byte_done) rx_any_d = 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d  = S_CMD;
                        phase_d  = 2'd0;
                        rx_any_d = 1'b0;
                        extra_d  = 1'b0;
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        if (byte_in == CMD_WRITE) begin
                            state_d = S_ADDR_HI;
                        end else if (byte_in == CMD_SWAP) begin
                            state_d = S_SWAP_WAIT;
                        end else begin
                            state_d = S_DISCARD;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (byte_done) begin
                        hi_d    = byte_in;
                        state_d = S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (byte_done) begin
                        // upper address bits beyond ADDR_W are dropped
                        addr_d  = ADDR_W'({hi_q, byte_in});
                        phase_d = 2'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_done) begin
                        unique case (phase_q)
                            2'd0: begin
                                r_d     = byte_in;
                                phase_d = 2'd1;
                            end
                            2'd1: begin
                                g_d     = byte_in;
                                phase_d = 2'd2;
                            end
                            2'd2: begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = {r_q, g_q, byte_in};
                                addr_d    = addr_q + ADDR_W'(1);
                                phase_d   = 2'd0;
                            end
                            default: phase_d = 2'd0;
                        endcase
                    end
                end
                S_SWAP_WAIT: begin
                    if (byte_done) extra_d = 1'b1;
                end
                S_DISCARD: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
